i2c_target: RTL



---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_monitor.sv | 52 +++++
 rtl/i2c_target.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus widths used by the target and the controller.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_WIDTH = 7;
  localparam int unsigned I2C_DATA_WIDTH = 8;
  localparam int unsigned SYNC_STAGES    = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    IGNORE
  } i2c_target_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes sda/scl into the clock domain and flags scl edges plus START/STOP conditions.
// All events are registered, giving a fixed 3-clock latency from the pins.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sda_pin,
  input  logic scl_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] sda_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic                   sda_d;
  logic                   scl_d;
  logic                   sda_n;
  logic                   scl_n;

  assign sda_n = sda_sync[SYNC_STAGES-1];
  assign scl_n = scl_sync[SYNC_STAGES-1];

  // Sync chains reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sda_sync  <= '1;
      scl_sync  <= '1;
      sda_d     <= 1'b1;
      scl_d     <= 1'b1;
      sda_s     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
      sda_d     <= sda_n;
      scl_d     <= scl_n;
      sda_s     <= sda_n;
      scl_rise  <= scl_n & ~scl_d;
      scl_fall  <= ~scl_n & scl_d;
      start_det <= scl_n & scl_d & sda_d & ~sda_n;
      stop_det  <= scl_n & scl_d & ~sda_d & sda_n;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: matches a 7-bit address, hands written bytes to the local side and
// fetches bytes from it for reads. Drives sda open-drain only; scl is never driven.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = I2C_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = I2C_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  tri                    sda,
  inout  tri                    scl,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  output logic                  addressed,
  output logic                  rw,
  output logic                  nack_seen,
  output logic                  busy
);

  i2c_target_state_t     state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_count;
  logic                  sda_low;
  logic                  tx_load;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_det;
  logic                  stop_det;
  logic                  sda_s;

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = 1'bz;

  i2c_bus_monitor u_bus_monitor (
    .clock     (clock),
    .reset     (reset),
    .sda_pin   (sda),
    .scl_pin   (scl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_count <= '0;
      sda_low   <= 1'b0;
      tx_load   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      nack_seen <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      nack_seen <= 1'b0;
      // Local side gets two clocks after tx_req to present the byte.
      tx_load   <= tx_req;
      if (tx_load) shreg <= tx_data;

      if (stop_det) begin
        state     <= IDLE;
        sda_low   <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b0;
        bit_count <= '0;
      end else if (start_det) begin
        state     <= ADDR;
        sda_low   <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b1;
        bit_count <= '0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[DATA_WIDTH-2:0], sda_s};
              if (bit_count == 4'(DATA_WIDTH - 1)) begin
                bit_count <= '0;
                if (shreg[ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                  rw    <= sda_s;
                  state <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end else begin
                bit_count <= bit_count + 4'd1;
              end
            end
          end
          // bit_count acts as a phase flag: 0 = ACK not yet driven.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_count == 4'd0) begin
                sda_low   <= 1'b1;
                addressed <= 1'b1;
                tx_req    <= rw;
                bit_count <= 4'd1;
              end else if (rw) begin
                sda_low   <= ~shreg[DATA_WIDTH-1];
                shreg     <= shreg << 1;
                bit_count <= 4'd1;
                state     <= TX_DATA;
              end else begin
                sda_low   <= 1'b0;
                bit_count <= '0;
                state     <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (scl_rise) begin
              shreg <= {shreg[DATA_WIDTH-2:0], sda_s};
              if (bit_count == 4'(DATA_WIDTH - 1)) begin
                rx_data   <= {shreg[DATA_WIDTH-2:0], sda_s};
                rx_valid  <= 1'b1;
                bit_count <= '0;
                state     <= RX_ACK;
              end else begin
                bit_count <= bit_count + 4'd1;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (bit_count == 4'd0) begin
                sda_low   <= 1'b1;
                bit_count <= 4'd1;
              end else begin
                sda_low   <= 1'b0;
                bit_count <= '0;
                state     <= RX_DATA;
              end
            end
          end
          // bit_count holds the number of bits of this byte already on the bus.
          TX_DATA: begin
            if (scl_fall) begin
              if (bit_count == 4'(DATA_WIDTH)) begin
                sda_low   <= 1'b0;
                bit_count <= '0;
                state     <= TX_ACK;
              end else begin
                sda_low   <= ~shreg[DATA_WIDTH-1];
                shreg     <= shreg << 1;
                bit_count <= bit_count + 4'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              bit_count <= '0;
              if (!sda_s) begin
                tx_req <= 1'b1;
                state  <= TX_DATA;
              end else begin
                nack_seen <= 1'b1;
                state     <= IGNORE;
              end
            end
          end
          IGNORE:  sda_low <= 1'b0;
          default: state   <= IDLE;
        endcase
      end
    end
  end

endmodule
